ctrl_decode_pipe: RTL and testbench
===================================

// Module: ctrl_decode_pipe
// PURPOSE
//  Parametrised successor to the single-cycle main control decoder. Decodes the
//  ID-stage opcode into WB/MEM/EX control bundles and registers them into the
//  ID/EX boundary. Adds ADDI/BNE/J decode, load-use hazard detection with
//  bubble insertion, external stall (hold) and a branch-shadow flush counter.
//  Sits between the instruction register and the ID/EX pipeline register.
// PARAMETERS
//  OPW     6  opcode width
//  REGW    5  register-specifier width
//  SHADOW  1  bubbles inserted after branch_taken (>=1, <=15)
//  LU_EN   1  1 = load-use detection enabled; 0 = hu_stall tied 0
// PORTS
//  clk          in   1     clock, rising edge
//  rst          in   1     asynchronous, active-high reset
//  opcode       in   OPW   ID-stage opcode
//  id_rs        in   REGW  ID-stage rs field
//  id_rt        in   REGW  ID-stage rt field
//  stall_in     in   1     downstream stall: hold all state
//  branch_taken in   1     branch resolved taken: start flush
//  wb           out  2     {reg_write, mem_to_reg}
//  mem          out  3     {branch, mem_read, mem_write}
//  ex           out  4     {reg_dst, alu_op[1:0], alu_src}
//  br_ne        out  1     branch sense: 1 = BNE
//  jump         out  1     unconditional jump
//  ex_rt        out  REGW  registered id_rt (load destination for hazard check)
//  valid_out    out  1     registered bundle is a real instruction (0 = bubble)
//  illegal_op   out  1     registered: last decoded opcode was unknown
//  hu_stall     out  1     combinational: freeze PC/IF-ID this cycle
// BEHAVIOUR
//  - Reset (async): all registered outputs 0; shadow counter 0.
//  - hu_stall = LU_EN & mem[1] & valid_out & (ex_rt==id_rs | ex_rt==id_rt).
//  - Decode table (wb/mem/ex/br_ne/jump):
//      RTYPE 000000: 10/000/1100/0/0    LW   100011: 11/010/0001/0/0
//      SW    101011: 00/001/0001/0/0    BEQ  000100: 00/100/0100/0/0
//      BNE   000101: 00/100/0100/1/0    ADDI 001000: 10/000/0001/0/0
//      J     000010: 00/000/0000/0/1    NOP  100000: all 0, valid_out=1
//    Unknown opcode: all 0, valid_out=0, illegal_op=1.
//  - Bubble = wb,mem,ex,br_ne,jump,valid_out,illegal_op all 0; ex_rt := 0.
//  - Latency 1 cycle: opcode at edge N appears on outputs after edge N.
//  - Per-edge priority (highest first):
//    1 rst.
//    2 flush = branch_taken | (cnt != 0): load bubble.
//      branch_taken: cnt := SHADOW-1. Otherwise: cnt := cnt-1.
//      branch_taken while cnt != 0 reloads cnt (no accumulation).
//    3 stall_in: hold all outputs and ex_rt.
//    4 hu_stall: load bubble; the next edge re-decodes the held opcode.
//    5 otherwise: load the decode of opcode/id_rt.
//  - Total bubbles from one isolated branch_taken = SHADOW. Flush wins over
//    stall_in: cnt decrements even while stall_in is high.
//  - hu_stall is never asserted the cycle after a bubble (valid_out gate), so a
//    load-use costs exactly one bubble.
// STRUCTURE
//  - Shared package ctrl_pkg: opcode localparams; WB/MEM/EX field-index
//    constants; bubble constant.
//  - One sub-module, ctrl_decode_comb: pure combinational opcode ->
//    {wb, mem, ex, br_ne, jump, valid, illegal}, reused by later decoders.
//  - Top holds ID/EX registers, shadow counter (4 bits) and hazard compare.
// TESTING
//  1 Each table opcode, no stall -> after 1 edge: exact table bundle; 6'b111111
//    -> bubble, illegal_op=1.
//  2 LW rt=5, then RTYPE rs=5 -> hu_stall=1 for one cycle, one bubble
//    (valid_out=0), then RTYPE bundle 10/000/1100.
//  3 SHADOW=3, branch_taken pulse -> exactly 3 bubble cycles, then decode
//    resumes; second pulse at bubble 2 -> 3 more bubbles from that point.
//  4 stall_in=1 for 4 cycles while opcode changes -> outputs frozen;
//    branch_taken during stall_in -> bubble anyway.
//  5 rst asserted mid-flush, between edges -> outputs 0 immediately, cnt=0;
//    after release, decode resumes on first edge.
//  6 LU_EN=0, LW/use pair -> hu_stall stays 0, no bubble.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared control-decode definitions: opcodes, bundle field indices, bubble.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_NOP   = 6'b100000;

  // wb = {reg_write, mem_to_reg}
  localparam int WB_REG_WRITE  = 1;
  localparam int WB_MEM_TO_REG = 0;
  // mem = {branch, mem_read, mem_write}
  localparam int MEM_BRANCH = 2;
  localparam int MEM_READ   = 1;
  localparam int MEM_WRITE  = 0;
  // ex = {reg_dst, alu_op[1:0], alu_src}
  localparam int EX_REG_DST = 3;
  localparam int EX_ALU_OP1 = 2;
  localparam int EX_ALU_OP0 = 1;
  localparam int EX_ALU_SRC = 0;

  typedef struct packed {
    logic [1:0] wb;
    logic [2:0] mem;
    logic [3:0] ex;
    logic       br_ne;
    logic       jump;
    logic       valid;
    logic       illegal;
  } ctrl_t;

  // A bubble carries no side effects and is not a real instruction.
  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_decode_comb.sv
// Pure combinational opcode -> control bundle decoder.
module ctrl_decode_comb
  import ctrl_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic [OPW-1:0] opcode,
  output logic [1:0]     wb,
  output logic [2:0]     mem,
  output logic [3:0]     ex,
  output logic           br_ne,
  output logic           jump,
  output logic           valid,
  output logic           illegal
);

  // Table lookup; anything not listed decodes as an illegal, invalid bundle.
  always_comb begin
    wb      = 2'b00;
    mem     = 3'b000;
    ex      = 4'b0000;
    br_ne   = 1'b0;
    jump    = 1'b0;
    valid   = 1'b1;
    illegal = 1'b0;
    case (opcode)
      OPW'(OP_RTYPE): begin wb = 2'b10; ex = 4'b1100; end
      OPW'(OP_LW):    begin wb = 2'b11; mem = 3'b010; ex = 4'b0001; end
      OPW'(OP_SW):    begin mem = 3'b001; ex = 4'b0001; end
      OPW'(OP_BEQ):   begin mem = 3'b100; ex = 4'b0100; end
      OPW'(OP_BNE):   begin mem = 3'b100; ex = 4'b0100; br_ne = 1'b1; end
      OPW'(OP_ADDI):  begin wb = 2'b10; ex = 4'b0001; end
      OPW'(OP_J):     jump = 1'b1;
      OPW'(OP_NOP):   ;
      default: begin
        valid   = 1'b0;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ctrl_decode_pipe.sv
// ID-stage control decode registered into ID/EX, with load-use bubble,
// downstream hold and branch-shadow flush.
module ctrl_decode_pipe
  import ctrl_pkg::*;
#(
  parameter int OPW    = 6,
  parameter int REGW   = 5,
  parameter int SHADOW = 1,
  parameter int LU_EN  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OPW-1:0]  opcode,
  input  logic [REGW-1:0] id_rs,
  input  logic [REGW-1:0] id_rt,
  input  logic            stall_in,
  input  logic            branch_taken,
  output logic [1:0]      wb,
  output logic [2:0]      mem,
  output logic [3:0]      ex,
  output logic            br_ne,
  output logic            jump,
  output logic [REGW-1:0] ex_rt,
  output logic            valid_out,
  output logic            illegal_op,
  output logic            hu_stall
);

  ctrl_t           dec;
  ctrl_t           q;
  logic [REGW-1:0] ex_rt_q;
  logic [3:0]      cnt;
  logic            flush;

  ctrl_decode_comb #(.OPW(OPW)) u_dec (
    .opcode  (opcode),
    .wb      (dec.wb),
    .mem     (dec.mem),
    .ex      (dec.ex),
    .br_ne   (dec.br_ne),
    .jump    (dec.jump),
    .valid   (dec.valid),
    .illegal (dec.illegal)
  );

  // Load in EX writing a register that ID reads; valid gate keeps the
  // bubble we inserted from re-triggering, so a load-use costs one cycle.
  always_comb begin
    hu_stall = (LU_EN != 0) && q.mem[MEM_READ] && q.valid &&
               ((ex_rt_q == id_rs) || (ex_rt_q == id_rt));
  end

  assign flush = branch_taken || (cnt != 4'd0);

  // ID/EX register and shadow counter; flush outranks the downstream hold
  // so the shadow always drains on schedule.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q       <= CTRL_BUBBLE;
      ex_rt_q <= '0;
      cnt     <= 4'd0;
    end else if (flush) begin
      q       <= CTRL_BUBBLE;
      ex_rt_q <= '0;
      cnt     <= branch_taken ? 4'(SHADOW - 1) : cnt - 4'd1;
    end else if (stall_in) begin
      q       <= q;
      ex_rt_q <= ex_rt_q;
    end else if (hu_stall) begin
      q       <= CTRL_BUBBLE;
      ex_rt_q <= '0;
    end else begin
      q       <= dec;
      ex_rt_q <= id_rt;
    end
  end

  assign wb         = q.wb;
  assign mem        = q.mem;
  assign ex         = q.ex;
  assign br_ne      = q.br_ne;
  assign jump       = q.jump;
  assign valid_out  = q.valid;
  assign illegal_op = q.illegal;
  assign ex_rt      = ex_rt_q;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Bench for ctrl_decode_pipe: opcode table, load-use, shadow flush, hold,
// mid-flush reset, and a load-use-disabled instance.
module tb_ctrl_decode_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic [4:0] id_rs, id_rt;
  logic       stall_in, branch_taken;

  logic [1:0] wb, wb0;
  logic [2:0] mem, mem0;
  logic [3:0] ex, ex0;
  logic       br_ne, br_ne0, jump, jump0;
  logic [4:0] ex_rt, ex_rt0;
  logic       valid_out, valid_out0, illegal_op, illegal_op0, hu_stall, hu_stall0;

  always #5 clk = ~clk;

  ctrl_decode_pipe #(.OPW(6), .REGW(5), .SHADOW(3), .LU_EN(1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .id_rs(id_rs), .id_rt(id_rt),
    .stall_in(stall_in), .branch_taken(branch_taken),
    .wb(wb), .mem(mem), .ex(ex), .br_ne(br_ne), .jump(jump), .ex_rt(ex_rt),
    .valid_out(valid_out), .illegal_op(illegal_op), .hu_stall(hu_stall)
  );

  ctrl_decode_pipe #(.OPW(6), .REGW(5), .SHADOW(1), .LU_EN(0)) dut0 (
    .clk(clk), .rst(rst), .opcode(opcode), .id_rs(id_rs), .id_rt(id_rt),
    .stall_in(stall_in), .branch_taken(branch_taken),
    .wb(wb0), .mem(mem0), .ex(ex0), .br_ne(br_ne0), .jump(jump0), .ex_rt(ex_rt0),
    .valid_out(valid_out0), .illegal_op(illegal_op0), .hu_stall(hu_stall0)
  );

  // {wb, mem, ex, br_ne, jump, valid_out, illegal_op}
  wire [12:0] bundle  = {wb, mem, ex, br_ne, jump, valid_out, illegal_op};
  wire [12:0] bundle0 = {wb0, mem0, ex0, br_ne0, jump0, valid_out0, illegal_op0};

  localparam logic [12:0] B_RTYPE = {2'b10, 3'b000, 4'b1100, 4'b0010};
  localparam logic [12:0] B_LW    = {2'b11, 3'b010, 4'b0001, 4'b0010};
  localparam logic [12:0] B_SW    = {2'b00, 3'b001, 4'b0001, 4'b0010};
  localparam logic [12:0] B_BEQ   = {2'b00, 3'b100, 4'b0100, 4'b0010};
  localparam logic [12:0] B_BNE   = {2'b00, 3'b100, 4'b0100, 4'b1010};
  localparam logic [12:0] B_ADDI  = {2'b10, 3'b000, 4'b0001, 4'b0010};
  localparam logic [12:0] B_J     = {2'b00, 3'b000, 4'b0000, 4'b0110};
  localparam logic [12:0] B_NOP   = {2'b00, 3'b000, 4'b0000, 4'b0010};
  localparam logic [12:0] B_ILL   = {2'b00, 3'b000, 4'b0000, 4'b0001};
  localparam logic [12:0] B_BUB   = 13'd0;

  typedef struct {
    logic [5:0]  op;
    logic [12:0] exp;
  } vec_t;

  typedef struct {
    logic [12:0] bundle;
    logic [4:0]  rt;
    string       name;
  } exp_t;

  vec_t tbl[9];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one ID-stage cycle, check hazard output, push the expected ID/EX
  // contents and compare them after the edge.
  task automatic drive(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic st, input logic bt, input logic [12:0] exp_b,
                       input logic [4:0] exp_rt, input logic exp_hu, input string nm);
    exp_t e;
    opcode = op; id_rs = rs; id_rt = rt; stall_in = st; branch_taken = bt;
    #1;
    chk({nm, "_hu"}, 32'(hu_stall), 32'(exp_hu));
    sb.push_back('{bundle: exp_b, rt: exp_rt, name: nm});
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      e = sb.pop_front();
      chk({e.name, "_bundle"}, 32'(bundle), 32'(e.bundle));
      chk({e.name, "_ex_rt"}, 32'(ex_rt), 32'(e.rt));
    end
  endtask

  initial begin
    tbl[0] = '{OP_RTYPE_C(), B_RTYPE};
    tbl[1] = '{6'b100011, B_LW};
    tbl[2] = '{6'b101011, B_SW};
    tbl[3] = '{6'b000100, B_BEQ};
    tbl[4] = '{6'b000101, B_BNE};
    tbl[5] = '{6'b001000, B_ADDI};
    tbl[6] = '{6'b000010, B_J};
    tbl[7] = '{6'b100000, B_NOP};
    tbl[8] = '{6'b111111, B_ILL};

    rst = 1'b1; opcode = '0; id_rs = '0; id_rt = '0; stall_in = 1'b0; branch_taken = 1'b0;
    #3;
    chk("reset_bundle", 32'(bundle), 32'(B_BUB));
    chk("reset_ex_rt", 32'(ex_rt), 32'd0);
    chk("reset_bundle0", 32'(bundle0), 32'(B_BUB));
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // opcode table, no stalls
    for (int i = 0; i < 9; i++)
      drive(tbl[i].op, 5'(20 + i), 5'(10 + i), 1'b0, 1'b0, tbl[i].exp, 5'(10 + i), 1'b0,
            $sformatf("tbl%0d", i));

    // load-use: one bubble, then the held RTYPE
    drive(6'b100011, 5'd0, 5'd5, 1'b0, 1'b0, B_LW,    5'd5, 1'b0, "lu_lw");
    drive(6'b000000, 5'd5, 5'd7, 1'b0, 1'b0, B_BUB,   5'd0, 1'b1, "lu_bubble");
    drive(6'b000000, 5'd5, 5'd7, 1'b0, 1'b0, B_RTYPE, 5'd7, 1'b0, "lu_rtype");

    // branch shadow of 3, then a reload from inside the shadow
    drive(6'b000000, 5'd1, 5'd2, 1'b0, 1'b1, B_BUB,   5'd0, 1'b0, "sh_b1");
    drive(6'b000000, 5'd1, 5'd2, 1'b0, 1'b0, B_BUB,   5'd0, 1'b0, "sh_b2");
    drive(6'b000000, 5'd1, 5'd2, 1'b0, 1'b0, B_BUB,   5'd0, 1'b0, "sh_b3");
    drive(6'b000000, 5'd1, 5'd2, 1'b0, 1'b0, B_RTYPE, 5'd2, 1'b0, "sh_resume");
    drive(6'b000000, 5'd1, 5'd2, 1'b0, 1'b1, B_BUB,   5'd0, 1'b0, "rl_b1");
    drive(6'b000000, 5'd1, 5'd2, 1'b0, 1'b0, B_BUB,   5'd0, 1'b0, "rl_b2");
    drive(6'b000000, 5'd1, 5'd2, 1'b0, 1'b1, B_BUB,   5'd0, 1'b0, "rl_r1");
    drive(6'b000000, 5'd1, 5'd2, 1'b0, 1'b0, B_BUB,   5'd0, 1'b0, "rl_r2");
    drive(6'b000000, 5'd1, 5'd2, 1'b0, 1'b0, B_BUB,   5'd0, 1'b0, "rl_r3");
    drive(6'b000000, 5'd1, 5'd2, 1'b0, 1'b0, B_RTYPE, 5'd2, 1'b0, "rl_resume");

    // downstream hold freezes outputs; flush still bubbles under hold
    drive(6'b001000, 5'd1, 5'd3, 1'b0, 1'b0, B_ADDI, 5'd3, 1'b0, "st_addi");
    drive(6'b000010, 5'd1, 5'd8, 1'b1, 1'b0, B_ADDI, 5'd3, 1'b0, "st_hold1");
    drive(6'b101011, 5'd2, 5'd9, 1'b1, 1'b0, B_ADDI, 5'd3, 1'b0, "st_hold2");
    drive(6'b000100, 5'd4, 5'd6, 1'b1, 1'b0, B_ADDI, 5'd3, 1'b0, "st_hold3");
    drive(6'b100000, 5'd6, 5'd1, 1'b1, 1'b0, B_ADDI, 5'd3, 1'b0, "st_hold4");
    drive(6'b000000, 5'd1, 5'd4, 1'b1, 1'b1, B_BUB,  5'd0, 1'b0, "st_fl1");
    drive(6'b000000, 5'd1, 5'd4, 1'b1, 1'b0, B_BUB,  5'd0, 1'b0, "st_fl2");
    drive(6'b000000, 5'd1, 5'd4, 1'b1, 1'b0, B_BUB,  5'd0, 1'b0, "st_fl3");
    drive(6'b000000, 5'd1, 5'd4, 1'b0, 1'b0, B_RTYPE, 5'd4, 1'b0, "st_resume");

    // reset mid-flush clears the shadow counter
    drive(6'b000000, 5'd1, 5'd6, 1'b0, 1'b1, B_BUB, 5'd0, 1'b0, "rs_b1");
    drive(6'b000000, 5'd1, 5'd6, 1'b0, 1'b0, B_BUB, 5'd0, 1'b0, "rs_b2");
    rst = 1'b1; #1;
    chk("rs_mid_bundle", 32'(bundle), 32'(B_BUB));
    rst = 1'b0;
    drive(6'b000000, 5'd1, 5'd6, 1'b0, 1'b0, B_RTYPE, 5'd6, 1'b0, "rs_resume");
    rst = 1'b1; #1;
    chk("rs_async_bundle", 32'(bundle), 32'(B_BUB));
    chk("rs_async_ex_rt", 32'(ex_rt), 32'd0);
    chk("rs_async_bundle0", 32'(bundle0), 32'(B_BUB));
    rst = 1'b0;

    // load-use detection disabled on dut0
    drive(6'b100011, 5'd0, 5'd5, 1'b0, 1'b0, B_LW, 5'd5, 1'b0, "lu0_lw");
    chk("lu0_lw_bundle0", 32'(bundle0), 32'(B_LW));
    opcode = 6'b000000; id_rs = 5'd5; id_rt = 5'd7;
    #1;
    chk("lu0_hu0", 32'(hu_stall0), 32'd0);
    chk("lu0_hu", 32'(hu_stall), 32'd1);
    @(posedge clk); #1;
    chk("lu0_bundle0", 32'(bundle0), 32'(B_RTYPE));
    chk("lu0_ex_rt0", 32'(ex_rt0), 32'd7);
    chk("lu0_dut_bubble", 32'(bundle), 32'(B_BUB));

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  function automatic logic [5:0] OP_RTYPE_C();
    return 6'b000000;
  endfunction

endmodule
